// File: rtl/mult_booth_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_booth_seq_pkg
// Shared definitions for the sequential radix-2 Booth multiplier:
//   - state_e     : controller states (IDLE / RUN / DONE)
//   - WIDTH       : operand and result width (only 32 is supported)
//   - STEPS       : number of Booth iterations (equals WIDTH)
//   - CNT_W       : step counter width
//   - fits_signed32() : true when a product's upper bits are pure sign
// -----------------------------------------------------------------------------
package mult_booth_seq_pkg;

    localparam int WIDTH = 32;
    localparam int STEPS = 32;
    localparam int CNT_W = 6;

    // Counter value seen on the edge that performs the final Booth step.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // P[63:31] of the product all equal means the value fits in 32 signed bits.
    function automatic logic fits_signed32(input logic [WIDTH:0] hi);
        return (hi == {(WIDTH + 1){1'b0}}) || (hi == {(WIDTH + 1){1'b1}});
    endfunction

endpackage

// File: rtl/mult_booth_seq_if.sv
// -----------------------------------------------------------------------------
// mult_booth_seq_if
// Start/operand/result bundle of the Booth multiplier.
//   ctrl_mult       : start pulse (master -> slave)
//   data_operandA   : multiplicand, two's complement (master -> slave)
//   data_operandB   : multiplier, two's complement (master -> slave)
//   data_result     : product bits [31:0] (slave -> master)
//   data_exception  : product does not fit in 32 signed bits (slave -> master)
//   data_resultRDY  : one-cycle result-valid pulse (slave -> master)
//   busy            : multiplier is iterating (slave -> master)
// -----------------------------------------------------------------------------
interface mult_booth_seq_if;
    import mult_booth_seq_pkg::*;

    logic             ctrl_mult;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_mult,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
    );

    modport slave (
        input  ctrl_mult,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
    );

endinterface

// File: rtl/mult_booth_seq_cla32.sv
// -----------------------------------------------------------------------------
// mult_booth_seq_cla32
// The cla32 adder: 32-bit carry-lookahead adder made of four 8-bit lookahead
// slices. Each slice exports group propagate/generate; a second-level
// lookahead unit derives the slice carry-ins (c8, c16, c24) and the carry
// out (c32) directly from those group signals and cin, so no carry ripples
// from one slice into the next.
//   x, y : addends
//   cin  : carry in
//   sum  : x + y + cin, bits [31:0]
//   cout : carry out of bit 31
// -----------------------------------------------------------------------------
module mult_booth_seq_cla32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] p_s;      // bit propagate
    logic [31:0] g_s;      // bit generate
    logic [31:0] c_s;      // carry into each bit
    logic [3:0]  gp_s;     // slice group propagate
    logic [3:0]  gg_s;     // slice group generate
    logic [3:0]  sc_s;     // carry into each slice

    // Bit-level propagate/generate and per-slice group P/G in sum-of-products form.
    always_comb begin
        logic term_v;
        p_s  = x ^ y;
        g_s  = x & y;
        gp_s = 4'b0000;
        gg_s = 4'b0000;
        term_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gp_s[k] = &p_s[8*k +: 8];
            for (int i = 0; i < 8; i++) begin
                // g_i propagated through every higher bit of the slice
                term_v = g_s[8*k + i];
                for (int j = i + 1; j < 8; j++) begin
                    term_v = term_v & p_s[8*k + j];
                end
                gg_s[k] = gg_s[k] | term_v;
            end
        end
    end

    // Second-level lookahead: every slice carry expanded from group P/G and cin.
    always_comb begin
        sc_s[0] = cin;
        sc_s[1] = gg_s[0] | (gp_s[0] & cin);
        sc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
        sc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
        cout    = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & cin);
    end

    // In-slice lookahead carries (each bit's carry expanded from the slice carry-in) and sum.
    always_comb begin
        logic carry_v;
        logic prod_v;
        c_s     = 32'h0000_0000;
        carry_v = 1'b0;
        prod_v  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                // slice carry-in propagated through bits 0..j-1
                carry_v = sc_s[k];
                for (int m = 0; m < j; m++) begin
                    carry_v = carry_v & p_s[8*k + m];
                end
                // plus each generate g_m propagated through bits m+1..j-1
                for (int m = 0; m < j; m++) begin
                    prod_v = g_s[8*k + m];
                    for (int q = m + 1; q < j; q++) begin
                        prod_v = prod_v & p_s[8*k + q];
                    end
                    carry_v = carry_v | prod_v;
                end
                c_s[8*k + j] = carry_v;
            end
        end
        sum = p_s ^ c_s;
    end

endmodule

// File: rtl/mult_booth_seq.sv
// -----------------------------------------------------------------------------
// mult_booth_seq
// Sequential 32x32 signed radix-2 Booth multiplier. One Booth step (optional
// add/subtract of the multiplicand into the upper product half, then an
// arithmetic right shift of the whole product register) per clock. Ready is
// signalled 32 edges after the start edge.
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : mult_booth_seq_if.slave (ctrl_mult, data_operandA/B in;
//           data_result, data_exception, data_resultRDY, busy out)
// Product register R[65:0]: R[65:33] is the 33-bit accumulating upper half,
// R[32:1] holds the remaining multiplier bits, R[0] is the Booth history bit.
// -----------------------------------------------------------------------------
module mult_booth_seq
    import mult_booth_seq_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    mult_booth_seq_if.slave    bus
);

    localparam int RW = 2 * WIDTH + 2;   // product register width (66)

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH:0]     a_q,      a_d;       // multiplicand, sign-extended to 33 bits
    logic [RW-1:0]      r_q,      r_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q,    exc_d;
    logic               rdy_q,    rdy_d;
    logic               busy_q,   busy_d;

    logic               booth_add_s;
    logic               booth_sub_s;
    logic [WIDTH:0]     aop_s;               // A or ~A feeding the adder
    logic [WIDTH-1:0]   cla_sum_s;
    logic               cla_cout_s;
    logic [WIDTH:0]     upper_s;             // R[65:33] after the optional add
    logic [RW-1:0]      r_step_s;            // R after add and shift

    // Booth recoding of the two low product bits: 01 adds A, 10 subtracts A.
    always_comb begin
        booth_add_s = 1'b0;
        booth_sub_s = 1'b0;
        case (r_q[1:0])
            2'b01:   begin booth_add_s = 1'b1; booth_sub_s = 1'b0; end
            2'b10:   begin booth_add_s = 1'b1; booth_sub_s = 1'b1; end
            default: begin booth_add_s = 1'b0; booth_sub_s = 1'b0; end
        endcase
    end

    // Subtraction is ~A with the adder carry-in set.
    always_comb begin
        if (booth_sub_s) begin
            aop_s = ~a_q;
        end else begin
            aop_s = a_q;
        end
    end

    mult_booth_seq_cla32 u_cla32 (
        .x    (r_q[RW-2:WIDTH+1]),
        .y    (aop_s[WIDTH-1:0]),
        .cin  (booth_sub_s),
        .sum  (cla_sum_s),
        .cout (cla_cout_s)
    );

    // Bit 32 of the upper half is a single full-adder sum bit on top of the
    // 32-bit adder; keeping 33 bits is what makes A = -2^31 negate correctly.
    always_comb begin
        if (booth_add_s) begin
            upper_s = {r_q[RW-1] ^ aop_s[WIDTH] ^ cla_cout_s, cla_sum_s};
        end else begin
            upper_s = r_q[RW-1:WIDTH+1];
        end
        r_step_s = {upper_s[WIDTH], upper_s, r_q[WIDTH:1]};
    end

    // Next-state, datapath-load and output-register logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        r_d      = r_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        if (bus.ctrl_mult) begin
            // A start in any state wins: RUN is restarted, DONE still ends
            // its ready pulse because rdy_q simply drops on this edge.
            a_d     = {bus.data_operandA[WIDTH-1], bus.data_operandA};
            r_d     = {{(WIDTH + 1){1'b0}}, bus.data_operandB, 1'b0};
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    r_d   = r_step_s;
                    cnt_d = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_STEP) begin
                        // P = R[64:1] after the final shift
                        state_d  = ST_DONE;
                        result_d = r_step_s[WIDTH:1];
                        exc_d    = ~fits_signed32(r_step_s[RW-2:WIDTH]);
                        rdy_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            a_q      <= {(WIDTH + 1){1'b0}};
            r_q      <= {RW{1'b0}};
            result_q <= {WIDTH{1'b0}};
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            r_q      <= r_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
// -----------------------------------------------------------------------------
// tb_mult_booth_seq
// Self-checking bench for mult_booth_seq. A cycle model built on plain 64-bit
// multiplication and a countdown tracks what the outputs must be; a negedge
// process compares all outputs to it every cycle. Directed cases pin both the
// DUT and the model to hand-computed values; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mult_booth_seq;

    logic clock;
    logic reset;
    mult_booth_seq_if bus();

    mult_booth_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_prod;
    int          m_left;
    logic        m_busy, m_rdy, m_exc;
    logic [31:0] m_res;

    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_res  <= 32'h0;
            m_exc  <= 1'b0;
            m_left <= 0;
            m_prod <= 64'h0;
        end else begin
            m_rdy <= 1'b0;
            if (bus.ctrl_mult) begin
                m_prod <= {{32{bus.data_operandA[31]}}, bus.data_operandA}
                        * {{32{bus.data_operandB[31]}}, bus.data_operandB};
                m_left <= 32;
                m_busy <= 1'b1;
            end else if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_rdy  <= 1'b1;
                    m_res  <= m_prod[31:0];
                    m_exc  <= (m_prod[63:32] != {32{m_prod[31]}});
                end
                m_left <= m_left - 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cyc_rdy",    {63'h0, bus.data_resultRDY}, {63'h0, m_rdy});
            chk("cyc_busy",   {63'h0, bus.busy},           {63'h0, m_busy});
            chk("cyc_result", {32'h0, bus.data_result},    {32'h0, m_res});
            chk("cyc_exc",    {63'h0, bus.data_exception}, {63'h0, m_exc});
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_mult     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        tick();
        bus.ctrl_mult     = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Ready must appear on edge E32, i.e. 32 edges after the start edge E0.
    task automatic wait_rdy(input string name);
        int edges;
        edges = 0;
        while (bus.data_resultRDY !== 1'b1 && edges < 100) begin
            tick();
            edges++;
        end
        chk(name, 64'(edges), 64'd32);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int pulses;
        reset             = 1'b1;
        bus.ctrl_mult     = 1'b0;
        bus.data_operandA = 32'h0;
        bus.data_operandB = 32'h0;
        repeat (3) tick();
        chk("rst_result", {32'h0, bus.data_result}, 64'h0);
        chk("rst_exc",    {63'h0, bus.data_exception}, 64'h0);
        chk("rst_rdy",    {63'h0, bus.data_resultRDY}, 64'h0);
        chk("rst_busy",   {63'h0, bus.busy}, 64'h0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        tick();

        // 3 x 5
        start(32'd3, 32'd5);
        chk("busy_after_start", {63'h0, bus.busy}, 64'h1);
        wait_rdy("lat_3x5");
        chk("res_3x5",   {32'h0, bus.data_result}, 64'h0000_000F);
        chk("exc_3x5",   {63'h0, bus.data_exception}, 64'h0);
        chk("model_3x5", {32'h0, m_res}, 64'h0000_000F);
        tick();
        chk("rdy_one_cycle", {63'h0, bus.data_resultRDY}, 64'h0);

        // -7 x 6
        start(32'hFFFF_FFF9, 32'h0000_0006);
        wait_rdy("lat_m7x6");
        chk("res_m7x6",   {32'h0, bus.data_result}, 64'hFFFF_FFD6);
        chk("exc_m7x6",   {63'h0, bus.data_exception}, 64'h0);
        chk("model_m7x6", {32'h0, m_res}, 64'hFFFF_FFD6);

        // back-to-back: start issued while in DONE
        start(32'h8000_0000, 32'h0000_0001);
        chk("b2b_busy", {63'h0, bus.busy}, 64'h1);
        wait_rdy("lat_b2b");
        chk("res_min_x1", {32'h0, bus.data_result}, 64'h8000_0000);
        chk("exc_min_x1", {63'h0, bus.data_exception}, 64'h0);
        tick();

        // overflow cases
        start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_rdy("lat_ovf1");
        chk("res_ovf1",   {32'h0, bus.data_result}, 64'h8000_0000);
        chk("exc_ovf1",   {63'h0, bus.data_exception}, 64'h1);
        chk("model_ovf1", {63'h0, m_exc}, 64'h1);
        tick();
        start(32'h0001_0000, 32'h0001_0000);
        wait_rdy("lat_ovf2");
        chk("res_ovf2", {32'h0, bus.data_result}, 64'h0);
        chk("exc_ovf2", {63'h0, bus.data_exception}, 64'h1);
        tick();

        // restart during RUN: only the second start produces a pulse
        start(32'd3, 32'd5);
        repeat (9) tick();
        start(32'd2, 32'd2);
        wait_rdy("lat_restart");
        chk("res_restart", {32'h0, bus.data_result}, 64'h4);
        chk("exc_restart", {63'h0, bus.data_exception}, 64'h0);
        tick();

        // reset mid-operation
        start(32'd9, 32'd9);
        repeat (14) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_result", {32'h0, bus.data_result}, 64'h0);
        chk("mid_rst_exc",    {63'h0, bus.data_exception}, 64'h0);
        chk("mid_rst_rdy",    {63'h0, bus.data_resultRDY}, 64'h0);
        chk("mid_rst_busy",   {63'h0, bus.busy}, 64'h0);
        reset  = 1'b0;
        pulses = 0;
        repeat (40) begin
            tick();
            if (bus.data_resultRDY === 1'b1) pulses++;
        end
        chk("aborted_no_rdy", 64'(pulses), 64'd0);
        start(32'd9, 32'd9);
        wait_rdy("lat_9x9");
        chk("res_9x9", {32'h0, bus.data_result}, 64'h0000_0051);

        // hold across idle cycles while operands wander
        for (int i = 0; i < 100; i++) begin
            bus.data_operandA = $urandom;
            bus.data_operandB = $urandom;
            tick();
            chk("hold_result", {32'h0, bus.data_result}, 64'h0000_0051);
        end

        // randomized starts with random gaps (covers restarts and DONE starts)
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 40)) tick();
            start(pick(), pick());
        end
        repeat (40) tick();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
